// File: rtl/game_pkg.sv
// Shared types and constants for the game scene renderer.
//   Colour constants: RGB565 palette used by the scene.
//   sprite_t        : one rectangle sprite register copy.
//   bg_state_t      : background flash FSM states.
package game_pkg;

    localparam int unsigned SPR_X_W  = 7;
    localparam int unsigned SPR_Y_W  = 6;
    localparam int unsigned COLOUR_W = 16;

    localparam logic [COLOUR_W-1:0] WHITE   = 16'hFFFF;
    localparam logic [COLOUR_W-1:0] BLACK   = 16'h0000;
    localparam logic [COLOUR_W-1:0] MAGENTA = 16'hF81F;
    localparam logic [COLOUR_W-1:0] CYAN    = 16'h07FF;
    localparam logic [COLOUR_W-1:0] BROWN   = 16'hA145;
    localparam logic [COLOUR_W-1:0] GREEN   = 16'h07E0;
    localparam logic [COLOUR_W-1:0] RED     = 16'hF800;
    localparam logic [COLOUR_W-1:0] BLUE    = 16'h001F;

    typedef struct packed {
        logic                en;
        logic [SPR_X_W-1:0]  x0;
        logic [SPR_X_W-1:0]  x1;
        logic [SPR_Y_W-1:0]  y0;
        logic [SPR_Y_W-1:0]  y1;
        logic [COLOUR_W-1:0] colour;
    } sprite_t;

    typedef enum logic [1:0] {
        BG_IDLE = 2'd0,
        BG_MAG  = 2'd1,
        BG_CYAN = 2'd2
    } bg_state_t;

    // Background colour shown in each flash state.
    function automatic logic [COLOUR_W-1:0] bg_colour(input bg_state_t s);
        case (s)
            BG_MAG:  bg_colour = MAGENTA;
            BG_CYAN: bg_colour = CYAN;
            default: bg_colour = WHITE;
        endcase
    endfunction

endpackage

// File: rtl/bg_flash_fsm.sv
// Animated background: IDLE (white) until active, then alternates
// MAGENTA/CYAN every FLASH_FRAMES frames. Advances only on frame_start.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   i_frame_start   : one-cycle pulse at frame start
//   i_active        : enables flashing
//   o_bg_colour     : registered colour of the current state
module bg_flash_fsm
    import game_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_frame_start,
    input  logic                i_active,
    output logic [COLOUR_W-1:0] o_bg_colour
);

    localparam int unsigned     PH_W    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(FLASH_FRAMES - 1);

    bg_state_t             r_state;
    bg_state_t             w_state_nxt;
    logic [PH_W-1:0]       r_phase;
    logic [PH_W-1:0]       w_phase_nxt;
    logic [COLOUR_W-1:0]   r_bg_colour;

    // State, phase and colour registers; colour tracks the next state so
    // it is valid in the same cycle the state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BG_IDLE;
            r_phase     <= '0;
            r_bg_colour <= WHITE;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_bg_colour <= bg_colour(w_state_nxt);
        end
    end

    // Next-state logic, evaluated only on frame boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        if (i_frame_start) begin
            case (r_state)
                BG_IDLE: begin
                    if (i_active) begin
                        w_state_nxt = BG_MAG;
                        w_phase_nxt = '0;
                    end
                end
                BG_MAG, BG_CYAN: begin
                    if (!i_active) begin
                        w_state_nxt = BG_IDLE;
                        w_phase_nxt = '0;
                    end else if (r_phase == PH_LAST) begin
                        w_state_nxt = (r_state == BG_MAG) ? BG_CYAN : BG_MAG;
                        w_phase_nxt = '0;
                    end else begin
                        w_phase_nxt = r_phase + PH_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = BG_IDLE;
                    w_phase_nxt = '0;
                end
            endcase
        end
    end

    assign o_bg_colour = r_bg_colour;

endmodule

// File: rtl/game_scene_renderer.sv
// Per-pixel scene renderer: up to NUM_SPRITES solid rectangles composited
// over an animated background, two-stage pipeline, RGB565 out.
// Sprite config is written to a shadow bank and committed to the live bank
// on frame_start so a frame never tears.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   i_x, i_y, i_pix_valid         : pixel request
//   i_frame_start, i_active       : frame pulse, background flash enable
//   i_cfg_valid / o_cfg_ready     : sprite config handshake
//   i_cfg_idx, i_cfg_en, i_cfg_x0/x1/y0/y1, i_cfg_colour : sprite config
//   o_oled_data, o_oled_valid     : pixel result, 2 cycles after request
module game_scene_renderer
    import game_pkg::*;
#(
    parameter  int unsigned NUM_SPRITES  = 4,
    parameter  int unsigned FLASH_FRAMES = 8,
    parameter  int unsigned X_W          = SPR_X_W,
    parameter  int unsigned Y_W          = SPR_Y_W,
    localparam int unsigned IDX_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [X_W-1:0]      i_x,
    input  logic [Y_W-1:0]      i_y,
    input  logic                i_pix_valid,
    input  logic                i_frame_start,
    input  logic                i_active,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [IDX_W-1:0]    i_cfg_idx,
    input  logic                i_cfg_en,
    input  logic [X_W-1:0]      i_cfg_x0,
    input  logic [X_W-1:0]      i_cfg_x1,
    input  logic [Y_W-1:0]      i_cfg_y0,
    input  logic [Y_W-1:0]      i_cfg_y1,
    input  logic [15:0]         i_cfg_colour,
    output logic [15:0]         o_oled_data,
    output logic                o_oled_valid
);

    logic                      w_cfg_fire;
    sprite_t                   w_cfg_spr;
    logic [SPR_X_W-1:0]        w_px;
    logic [SPR_Y_W-1:0]        w_py;
    logic [COLOUR_W-1:0]       w_bg_colour;
    logic [NUM_SPRITES-1:0]    w_hit;
    logic [COLOUR_W-1:0]       w_s1_col [NUM_SPRITES];
    logic [COLOUR_W-1:0]       w_pix_col;

    logic                      r_s1_valid;
    logic [NUM_SPRITES-1:0]    r_s1_hit;
    logic [COLOUR_W-1:0]       r_s1_bg;
    logic                      r_oled_valid;
    logic [COLOUR_W-1:0]       r_oled_data;

    // No write is taken in a commit cycle, so shadow never races live.
    assign o_cfg_ready = !i_frame_start;
    assign w_cfg_fire  = i_cfg_valid && o_cfg_ready;

    assign w_cfg_spr.en     = i_cfg_en;
    assign w_cfg_spr.x0     = SPR_X_W'(i_cfg_x0);
    assign w_cfg_spr.x1     = SPR_X_W'(i_cfg_x1);
    assign w_cfg_spr.y0     = SPR_Y_W'(i_cfg_y0);
    assign w_cfg_spr.y1     = SPR_Y_W'(i_cfg_y1);
    assign w_cfg_spr.colour = i_cfg_colour;

    assign w_px = SPR_X_W'(i_x);
    assign w_py = SPR_Y_W'(i_y);

    bg_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_bg_flash_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_start (i_frame_start),
        .i_active      (i_active),
        .o_bg_colour   (w_bg_colour)
    );

    // Per-sprite shadow/live registers, hit test and stage-1 colour capture.
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
        sprite_t             r_shadow;
        sprite_t             r_live;
        logic [COLOUR_W-1:0] r_s1_col;

        // Out-of-range indices match no sprite, so such writes are dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow <= '0;
            end else if (w_cfg_fire && (i_cfg_idx == IDX_W'(gi))) begin
                r_shadow <= w_cfg_spr;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_live <= '0;
            end else if (i_frame_start) begin
                r_live <= r_shadow;
            end
        end

        // Colour is captured alongside the hit so a commit between the
        // stages cannot change the result of an in-flight pixel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_col <= '0;
            end else if (i_pix_valid) begin
                r_s1_col <= r_live.colour;
            end
        end

        // Inverted bounds make one of the range terms false, so no hit.
        assign w_hit[gi] = r_live.en
                        && (w_px >= r_live.x0) && (w_px <= r_live.x1)
                        && (w_py >= r_live.y0) && (w_py <= r_live.y1);

        assign w_s1_col[gi] = r_s1_col;
    end

    // Stage 1: hit vector and background.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= '0;
            r_s1_bg    <= WHITE;
        end else begin
            r_s1_valid <= i_pix_valid;
            if (i_pix_valid) begin
                r_s1_hit <= w_hit;
                r_s1_bg  <= w_bg_colour;
            end
        end
    end

    // Priority mux: lowest-index hit wins, background otherwise.
    always_comb begin
        w_pix_col = r_s1_bg;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (r_s1_hit[i]) begin
                w_pix_col = w_s1_col[i];
            end
        end
    end

    // Stage 2: output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oled_valid <= 1'b0;
            r_oled_data  <= WHITE;
        end else begin
            r_oled_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_oled_data <= w_pix_col;
            end
        end
    end

    assign o_oled_valid = r_oled_valid;
    assign o_oled_data  = r_oled_data;

endmodule

// File: tb/tb_game_scene_renderer.sv
// Directed bench for game_scene_renderer with an expected-pixel scoreboard.
// A second instance with three sprites exercises an out-of-range cfg_idx.
module tb_game_scene_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  x = '0;
    logic [5:0]  y = '0;
    logic        pix_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        active = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_valid3 = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [1:0]  cfg_idx3 = '0;
    logic        cfg_en = 1'b0;
    logic [6:0]  cfg_x0 = '0;
    logic [6:0]  cfg_x1 = '0;
    logic [5:0]  cfg_y0 = '0;
    logic [5:0]  cfg_y1 = '0;
    logic [15:0] cfg_colour = '0;

    logic        cfg_ready;
    logic        cfg_ready3;
    logic [15:0] oled_data;
    logic [15:0] oled_data3;
    logic        oled_valid;
    logic        oled_valid3;

    typedef struct {
        string       tag;
        logic [15:0] exp;
        logic [15:0] exp3;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] bg_exp = 16'hFFFF;
    logic [15:0] tab [5] = '{16'hF81F, 16'hF81F, 16'h07FF, 16'h07FF, 16'hF81F};

    game_scene_renderer #(
        .NUM_SPRITES (4),
        .FLASH_FRAMES(2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_x          (x),
        .i_y          (y),
        .i_pix_valid  (pix_valid),
        .i_frame_start(frame_start),
        .i_active     (active),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_idx    (cfg_idx),
        .i_cfg_en     (cfg_en),
        .i_cfg_x0     (cfg_x0),
        .i_cfg_x1     (cfg_x1),
        .i_cfg_y0     (cfg_y0),
        .i_cfg_y1     (cfg_y1),
        .i_cfg_colour (cfg_colour),
        .o_oled_data  (oled_data),
        .o_oled_valid (oled_valid)
    );

    game_scene_renderer #(
        .NUM_SPRITES (3),
        .FLASH_FRAMES(2)
    ) u_dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_x          (x),
        .i_y          (y),
        .i_pix_valid  (pix_valid),
        .i_frame_start(frame_start),
        .i_active     (active),
        .i_cfg_valid  (cfg_valid3),
        .o_cfg_ready  (cfg_ready3),
        .i_cfg_idx    (cfg_idx3),
        .i_cfg_en     (cfg_en),
        .i_cfg_x0     (cfg_x0),
        .i_cfg_x1     (cfg_x1),
        .i_cfg_y0     (cfg_y0),
        .i_cfg_y1     (cfg_y1),
        .i_cfg_colour (cfg_colour),
        .o_oled_data  (oled_data3),
        .o_oled_valid (oled_valid3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard whenever a result appears.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (oled_valid || oled_valid3)) begin
            checks++;
            assert (q.size() > 0 && oled_valid === 1'b1)
                else begin errors++; $error("FAIL unexpected_valid got=%b exp=none", oled_valid); end
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                assert (oled_data === e.exp)
                    else begin errors++; $error("FAIL %s data got=%h exp=%h", e.tag, oled_data, e.exp); end
                checks++;
                assert ((cyc - e.cyc) === 2)
                    else begin errors++; $error("FAIL %s latency got=%0d exp=2", e.tag, cyc - e.cyc); end
                checks++;
                assert (oled_valid3 === 1'b1 && oled_data3 === e.exp3)
                    else begin errors++; $error("FAIL %s dut3 got=%b/%h exp=1/%h", e.tag, oled_valid3, oled_data3, e.exp3); end
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
            else begin errors++; $error("FAIL %s got=%h exp=%h", tag, got, exp); end
    endtask

    // All driver tasks start and end at a falling edge.
    task automatic pix(input string tag, input logic [6:0] px, input logic [5:0] py, input logic [15:0] exp);
        exp_t e;
        x = px; y = py; pix_valid = 1'b1;
        e.tag = tag; e.exp = exp; e.exp3 = bg_exp; e.cyc = cyc;
        q.push_back(e);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic pix_fs(input string tag, input logic [6:0] px, input logic [5:0] py, input logic [15:0] exp);
        frame_start = 1'b1;
        pix(tag, px, py, exp);
        frame_start = 1'b0;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wr(input logic [1:0] idx, input logic en, input logic [6:0] x0, input logic [6:0] x1,
                      input logic [5:0] y0, input logic [5:0] y1, input logic [15:0] col);
        cfg_valid = 1'b1; cfg_idx = idx; cfg_en = en;
        cfg_x0 = x0; cfg_x1 = x1; cfg_y0 = y0; cfg_y1 = y1; cfg_colour = col;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {15'd0, oled_valid}, 16'h0000);
        chk("rst_data", oled_data, 16'hFFFF);
        chk("rst_ready", {15'd0, cfg_ready}, 16'h0001);
        rst_n = 1'b1;
        @(negedge clk);

        // Ten pixels, no config
        for (int i = 0; i < 10; i++) pix("reset_px", 7'(i * 9), 6'(i * 6), 16'hFFFF);

        // Single sprite
        wr(2'd0, 1'b1, 7'd35, 7'd62, 6'd11, 6'd22, 16'h8204);
        pix("pre_commit", 7'd40, 6'd15, 16'hFFFF);
        pulse();
        pix("corner_in", 7'd35, 6'd11, 16'h8204);
        pix("left_out", 7'd34, 6'd11, 16'hFFFF);
        pix("far_corner", 7'd62, 6'd22, 16'h8204);
        pix("right_out", 7'd63, 6'd22, 16'hFFFF);
        pix("top_out", 7'd35, 6'd10, 16'hFFFF);

        // Pixel in the commit cycle sees the old live set
        wr(2'd0, 1'b1, 7'd35, 7'd62, 6'd11, 6'd22, 16'h07E0);
        pix_fs("commit_cycle", 7'd40, 6'd15, 16'h8204);
        pix("after_commit", 7'd40, 6'd15, 16'h07E0);

        // Priority
        wr(2'd0, 1'b1, 7'd0, 7'd50, 6'd0, 6'd63, 16'h0000);
        wr(2'd1, 1'b1, 7'd40, 7'd95, 6'd0, 6'd63, 16'hF800);
        pulse();
        pix("prio_overlap", 7'd45, 6'd10, 16'h0000);
        pix("prio_s1", 7'd60, 6'd10, 16'hF800);
        pix("prio_s0", 7'd20, 6'd5, 16'h0000);
        pix("prio_edge", 7'd95, 6'd63, 16'hF800);
        wr(2'd0, 1'b0, 7'd0, 7'd50, 6'd0, 6'd63, 16'h0000);
        pulse();
        pix("prio_s0_off", 7'd45, 6'd10, 16'hF800);
        pix("s0_off_bg", 7'd20, 6'd5, 16'hFFFF);

        // Inverted bounds never hit
        wr(2'd2, 1'b1, 7'd50, 7'd40, 6'd0, 6'd63, 16'h001F);
        wr(2'd3, 1'b1, 7'd0, 7'd10, 6'd30, 6'd20, 16'hA145);
        pulse();
        pix("inv_x", 7'd38, 6'd3, 16'hFFFF);
        pix("inv_x_s1", 7'd45, 6'd3, 16'hF800);
        pix("inv_y", 7'd5, 6'd25, 16'hFFFF);

        // Out-of-range index on the three-sprite instance
        cfg_valid3 = 1'b1; cfg_idx3 = 2'd3; cfg_en = 1'b1;
        cfg_x0 = 7'd0; cfg_x1 = 7'd95; cfg_y0 = 6'd0; cfg_y1 = 6'd63; cfg_colour = 16'hF800;
        #1 chk("oor_ready", {15'd0, cfg_ready3}, 16'h0001);
        @(negedge clk);
        cfg_valid3 = 1'b0;
        pulse();
        pix("oor_no_hit", 7'd5, 6'd5, 16'hFFFF);

        // cfg_valid held across a commit cycle
        cfg_valid = 1'b1; cfg_idx = 2'd3; cfg_en = 1'b1;
        cfg_x0 = 7'd0; cfg_x1 = 7'd10; cfg_y0 = 6'd0; cfg_y1 = 6'd63; cfg_colour = 16'h001F;
        frame_start = 1'b1;
        #1 chk("ready_in_commit", {15'd0, cfg_ready}, 16'h0000);
        @(negedge clk);
        frame_start = 1'b0;
        #1 chk("ready_after", {15'd0, cfg_ready}, 16'h0001);
        @(negedge clk);
        cfg_valid = 1'b0;
        pix("held_not_live", 7'd5, 6'd25, 16'hFFFF);
        pulse();
        pix("held_live", 7'd5, 6'd25, 16'h001F);

        // Flash sequence
        active = 1'b1;
        pix("flash_f0", 7'd30, 6'd0, 16'hFFFF);
        for (int k = 0; k < 5; k++) begin
            pulse();
            bg_exp = tab[k];
            pix("flash_bg", 7'd30, 6'd0, tab[k]);
            pix("flash_spr", 7'd5, 6'd0, 16'h001F);
        end
        active = 1'b0;
        pulse();
        bg_exp = 16'hFFFF;
        pix("flash_off", 7'd30, 6'd0, 16'hFFFF);
        active = 1'b1;
        repeat (3) pulse();
        bg_exp = 16'h07FF;
        pix("flash_cyan", 7'd30, 6'd0, 16'h07FF);

        // Reset with two pixels in flight
        begin
            exp_t e;
            x = 7'd30; y = 6'd0; pix_valid = 1'b1;
            e.tag = "inflight_a"; e.exp = 16'h07FF; e.exp3 = 16'h07FF; e.cyc = cyc;
            q.push_back(e);
            @(negedge clk);
            x = 7'd31;
            e.tag = "inflight_b"; e.cyc = cyc;
            q.push_back(e);
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("rst_mid_valid", {15'd0, oled_valid}, 16'h0000);
            chk("rst_mid_data", oled_data, 16'hFFFF);
            q.delete();
        end
        active = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bg_exp = 16'hFFFF;
        pix("post_rst_bg", 7'd30, 6'd0, 16'hFFFF);
        pix("post_rst_s3", 7'd5, 6'd0, 16'hFFFF);
        pix("post_rst_s1", 7'd45, 6'd10, 16'hFFFF);
        pulse();
        pix("post_rst_shadow3", 7'd5, 6'd0, 16'hFFFF);
        pix("post_rst_shadow1", 7'd45, 6'd10, 16'hFFFF);

        repeat (4) @(negedge clk);
        checks++;
        assert (q.size() == 0)
            else begin errors++; $error("FAIL drain got=%0d pending exp=0", q.size()); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
